// File: rtl/send_arbiter.sv
`timescale 1ns/1ps
// send_arbiter: round-robin arbiter that grants whole packets onto one
// registered egress stream, tagging each beat with its source index.
// Beats that arrive without an SOP while no packet is open are dropped
// and counted.
module send_arbiter #(
    parameter int NPORTS = 4,
    parameter int DW     = 64,
    parameter int CHW    = 2,
    parameter int ERRW   = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NPORTS*DW-1:0] in_data,
    input  logic [NPORTS-1:0]    in_valid,
    input  logic [NPORTS-1:0]    in_sop,
    input  logic [NPORTS-1:0]    in_eop,
    output logic [NPORTS-1:0]    in_ready,
    output logic [DW-1:0]        send_data,
    output logic                 send_valid,
    output logic                 send_sop,
    output logic                 send_eop,
    output logic [CHW-1:0]       send_channel,
    input  logic                 send_ready,
    output logic [ERRW-1:0]      err_count
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [CHW-1:0] grant_q, grant_d;
    logic [CHW-1:0] last_q, last_d;

    logic [DW-1:0]   data_q;
    logic            valid_q, sop_q, eop_q;
    logic [CHW-1:0]  chan_q;
    logic [ERRW-1:0] err_q;

    logic           adv;
    logic           cand_vld;
    logic [CHW-1:0] cand, idx;
    logic [CHW-1:0] sel;
    logic           rdy_any, accept, fwd, orphan;
    logic           sel_sop, sel_eop;
    logic [DW-1:0]  sel_data;

    // Output register may take a new beat when empty or being drained.
    assign adv = !valid_q || send_ready;

    // Rotating-priority search starting just after the last served port.
    // Walking from farthest to nearest lets the nearest requester win.
    always_comb begin
        cand_vld = 1'b0;
        cand     = last_q;
        idx      = last_q;
        for (int k = NPORTS; k >= 1; k--) begin
            idx = last_q + CHW'(k);
            if (in_valid[idx]) begin
                cand_vld = 1'b1;
                cand     = idx;
            end
        end
    end

    // Select the serviced port and decide what happens to its beat.
    always_comb begin
        sel      = (state_q == LOCKED) ? grant_q : cand;
        rdy_any  = reset_n && adv && ((state_q == LOCKED) || cand_vld);
        accept   = rdy_any && in_valid[sel];
        sel_sop  = in_sop[sel];
        sel_eop  = in_eop[sel];
        sel_data = in_data[sel*DW +: DW];
        fwd      = accept && ((state_q == LOCKED) || sel_sop);
        orphan   = accept && (state_q == IDLE) && !sel_sop;
        in_ready = rdy_any ? ({{(NPORTS-1){1'b0}}, 1'b1} << sel) : '0;
    end

    // Packet lock FSM; priority pointer moves only at packet or orphan end.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (accept) begin
            if (state_q == IDLE) begin
                if (sel_sop && !sel_eop) begin
                    grant_d = cand;
                    state_d = LOCKED;
                end else begin
                    last_d = cand;
                end
            end else if (sel_eop) begin
                last_d  = grant_q;
                state_d = IDLE;
            end
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= CHW'(NPORTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Egress register: loads a forwarded beat, empties on an idle advance.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
        end else if (adv) begin
            valid_q <= fwd;
            if (fwd) begin
                sop_q  <= sel_sop;
                eop_q  <= sel_eop;
                data_q <= sel_data;
                chan_q <= sel;
            end
        end
    end

    // Saturating count of dropped orphan beats.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            err_q <= '0;
        else if (orphan && (err_q != '1))
            err_q <= err_q + 1'b1;
    end

    assign send_data    = data_q;
    assign send_valid   = valid_q;
    assign send_sop     = sop_q;
    assign send_eop     = eop_q;
    assign send_channel = chan_q;
    assign err_count    = err_q;

endmodule

// File: tb/tb_send_arbiter.sv
`timescale 1ns/1ps
// Directed bench for send_arbiter: per-port packet sources driven from a
// small table, egress beats compared against hand-derived sequences.
module tb_send_arbiter;
    localparam int NP = 4;
    localparam int DW = 64;
    localparam int CW = 2;
    localparam int EW = 2;

    logic             clock, reset_n;
    logic [NP*DW-1:0] in_data;
    logic [NP-1:0]    in_valid, in_sop, in_eop, in_ready;
    logic [DW-1:0]    send_data;
    logic             send_valid, send_sop, send_eop, send_ready;
    logic [CW-1:0]    send_channel;
    logic [EW-1:0]    err_count;

    send_arbiter #(.NPORTS(NP), .DW(DW), .CHW(CW), .ERRW(EW)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
        .in_eop(in_eop), .in_ready(in_ready),
        .send_data(send_data), .send_valid(send_valid), .send_sop(send_sop),
        .send_eop(send_eop), .send_channel(send_channel),
        .send_ready(send_ready), .err_count(err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    // source model: active flag, packet length, beat position, packet number
    bit act [NP];
    int len [NP];
    int beat[NP];
    int pkt [NP];
    logic [NP-1:0] acc;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] dv(input int p, input int k, input int b);
        return 64'(p * 4096 + k * 16 + b);
    endfunction

    function automatic logic [95:0] pk(input logic v, input logic s, input logic e,
                                       input logic [1:0] ch, input logic [63:0] d);
        return {27'b0, v, s, e, ch, d};
    endfunction

    function automatic logic [95:0] obs_out();
        return pk(send_valid, send_sop, send_eop, send_channel, send_data);
    endfunction

    task automatic clr_model();
        for (int p = 0; p < NP; p++) begin
            act[p] = 0; len[p] = 1; beat[p] = 0; pkt[p] = 0;
        end
    endtask

    // drive this cycle's inputs, then move to the sampling point (negedge)
    task automatic pre();
        for (int p = 0; p < NP; p++) begin
            in_valid[p] = act[p];
            in_sop[p]   = act[p] && (beat[p] == 0);
            in_eop[p]   = act[p] && (beat[p] == len[p] - 1);
            in_data[p*DW +: DW] = dv(p, pkt[p], beat[p] + 1);
        end
        #4;
    endtask

    // capture handshakes, cross the edge, advance accepted sources
    task automatic post();
        acc = in_valid & in_ready;
        @(posedge clock);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (acc[p]) begin
                beat[p]++;
                if (beat[p] == len[p]) begin
                    beat[p] = 0;
                    pkt[p]++;
                end
            end
        end
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        send_ready = 1'b1;
        clr_model();
        in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    int t3b[9] = '{0, 1, 2, 2, 2, 2, 3, 4, 5};

    initial begin
        reset_n = 1'b0; send_ready = 1'b1;
        in_data = '0; in_sop = '0; in_eop = '0;
        in_valid = '1;
        clr_model();
        #12;
        // reset state, including ready suppression while in reset
        chk("rst_out", obs_out(), 96'd0);
        chk("rst_err", 96'(err_count), 96'd0);
        chk("rst_rdy", 96'(in_ready), 96'd0);

        // single source, 4-beat packets back to back
        do_reset();
        act[0] = 1; len[0] = 4;
        for (int k = 0; k <= 8; k++) begin
            pre();
            if (k >= 1) begin
                int i;
                i = k - 1;
                chk("single", obs_out(),
                    pk(1'b1, (i % 4) == 0, (i % 4) == 3, 2'd0, dv(0, i / 4, i % 4 + 1)));
            end
            post();
        end

        // all ports requesting 2-beat packets: 0,1,2,3,0,... no bubbles
        do_reset();
        for (int p = 0; p < NP; p++) begin act[p] = 1; len[p] = 2; end
        for (int k = 0; k <= 10; k++) begin
            pre();
            if (k >= 1) begin
                int i;
                i = k - 1;
                chk("rr_all", obs_out(),
                    pk(1'b1, (i % 2) == 0, (i % 2) == 1, 2'((i / 2) % 4),
                       dv((i / 2) % 4, i / 8, i % 2 + 1)));
            end
            post();
        end

        // backpressure for 3 cycles mid-packet
        do_reset();
        act[0] = 1; len[0] = 4;
        for (int k = 0; k <= 8; k++) begin
            send_ready = (k >= 2 && k <= 4) ? 1'b0 : 1'b1;
            pre();
            if (k >= 1) begin
                int n;
                n = t3b[k];
                chk("bp_out", obs_out(),
                    pk(1'b1, ((n - 1) % 4) == 0, ((n - 1) % 4) == 3, 2'd0,
                       dv(0, (n - 1) / 4, (n - 1) % 4 + 1)));
            end
            if (k >= 2 && k <= 5)
                chk("bp_rdy", 96'(in_ready), (k == 5) ? 96'd1 : 96'd0);
            post();
        end

        // orphan beats on port 2: dropped, counted, saturating at 3
        do_reset();
        act[2] = 1; len[2] = 100; beat[2] = 1;
        pre();
        chk("orph_rdy", 96'(in_ready), 96'd4);
        post();
        #4;
        chk("orph_cnt1", 96'(err_count), 96'd1);
        chk("orph_nout", 96'(send_valid), 96'd0);
        @(posedge clock); #1;
        for (int k = 0; k < 4; k++) begin
            pre();
            post();
        end
        #4;
        chk("orph_sat", 96'(err_count), 96'd3);
        chk("orph_nout2", 96'(send_valid), 96'd0);
        @(posedge clock); #1;

        // reset during beat 2 of a port 1 packet
        do_reset();
        act[1] = 1; len[1] = 4;
        for (int k = 0; k <= 1; k++) begin pre(); post(); end
        pre();
        chk("mid_b2", obs_out(), pk(1'b1, 1'b0, 1'b0, 2'd1, dv(1, 0, 2)));
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_vld", 96'(send_valid), 96'd0);
        chk("mid_rdy", 96'(in_ready), 96'd0);
        do_reset();
        act[0] = 1; len[0] = 2;
        act[1] = 1; len[1] = 2;
        for (int k = 0; k <= 3; k++) begin
            pre();
            if (k == 1) chk("post_rst1", obs_out(), pk(1'b1, 1'b1, 1'b0, 2'd0, dv(0, 0, 1)));
            if (k == 2) chk("post_rst2", obs_out(), pk(1'b1, 1'b0, 1'b1, 2'd0, dv(0, 0, 2)));
            if (k == 3) chk("post_rst3", obs_out(), pk(1'b1, 1'b1, 1'b0, 2'd1, dv(1, 0, 1)));
            post();
        end

        // single-beat packets on ports 1 and 3 alternate every cycle
        do_reset();
        act[1] = 1; len[1] = 1;
        act[3] = 1; len[3] = 1;
        for (int k = 0; k <= 6; k++) begin
            pre();
            if (k >= 1) begin
                int ch;
                ch = (k % 2 == 1) ? 1 : 3;
                chk("sb_alt", obs_out(), pk(1'b1, 1'b1, 1'b1, 2'(ch), dv(ch, (k - 1) / 2, 1)));
            end
            post();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
